imem_loader: RTL and testbench

- Writer side of the instruction-memory interface; the processor's fetch path is the reader.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into instruction memory through a synchronous write port.
- Holds the processor in reset (cpu_hold) until the program image is complete.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian
// 32-bit word writes and holds the processor in reset until the image is complete.
module imem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reload,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [2:0]        state_dbg
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
   // is registered and in_valid may toggle freely, a byte is consumed only on a transfer.
   localparam logic [2:0] S_LEN_HI = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_FIN    = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   logic [2:0]  state;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_sr;
   logic        xfer;
   logic [15:0] len_n;
   logic        word_last;

   assign xfer      = in_valid && in_ready;
   assign len_n     = {count[15:8], in_data};
   assign word_last = (word_idx == (count - 16'd1));
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_LEN_HI;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
         count    <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         word_sr  <= '0;
      end else if (reload) begin
         // Restart wins over a byte offered in the same cycle; memory contents stay.
         state    <= S_LEN_HI;
         in_ready <= 1'b1;
         wr_en    <= 1'b0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
         count    <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         word_sr  <= '0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_LEN_HI: begin
               in_ready <= 1'b1;
               if (xfer) begin
                  count[15:8] <= in_data;
                  state       <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  count[7:0] <= in_data;
                  if (len_n == 16'd0) begin
                     state    <= S_RUN;
                     in_ready <= 1'b0;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else if (len_n > DEPTH_W) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  if (byte_cnt == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= word_idx[ADDR_W-1:0];
                     wr_data  <= {word_sr, in_data};
                     byte_cnt <= 2'd0;
                     word_idx <= word_idx + 16'd1;
                     if (word_last) begin
                        state    <= S_FIN;
                        in_ready <= 1'b0;
                     end
                  end else begin
                     word_sr  <= {word_sr[15:0], in_data};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            S_FIN: begin
               // Final write is visible this cycle; release the processor next.
               state    <= S_RUN;
               cpu_hold <= 1'b0;
               done     <= 1'b1;
            end
            S_RUN: begin
               in_ready <= 1'b0;
            end
            S_ERR: begin
               in_ready <= 1'b0;
            end
            default: begin
               state    <= S_LEN_HI;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven loads, random loads against a stream model,
// and hand sequences for reload and reset in the middle of a word.
module tb_imem_loader;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int W      = ADDR_W + 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              reload = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [2:0]        state_dbg;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .reload(reload), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error), .state_dbg(state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic [7:0]   stream_q[$];
   logic [31:0]  words_q[$];
   logic [W-1:0] last_wr = '0;
   int           last_accept_cyc = 0;
   int           last_wr_cyc = 0;
   int           done_cyc = 0;
   int           done_cnt = 0;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   // scoreboard side: collect writes and done pulses, check write timing and hold
   always @(negedge clk) begin
      if (!rst) begin
         last_wr = '0;
      end else begin
         if (wr_en) begin
            got_q.push_back({wr_addr, wr_data});
            chk("wr_latency", 64'(cyc), 64'(last_accept_cyc));
            last_wr     = {wr_addr, wr_data};
            last_wr_cyc = cyc;
         end else begin
            chk("wr_hold", 64'({wr_addr, wr_data}), 64'(last_wr));
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 64'(in_ready), 64'd1);
      if (in_ready) begin
         @(posedge clk);
         #1;
         last_accept_cyc = cyc;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic play(input int gap_lo, input int gap_hi);
      for (int i = 0; i < stream_q.size(); i++)
         send_byte(stream_q[i], int'($urandom_range(gap_hi, gap_lo)));
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      #1;
      chk("reload_in_ready", 64'(in_ready), 64'd1);
      chk("reload_error", 64'(error), 64'd0);
      chk("reload_cpu_hold", 64'(cpu_hold), 64'd1);
      got_q.delete();
      done_cnt = 0;
   endtask

   // reference model: stream bytes and expected writes from a word count and word list
   task automatic build(input logic [15:0] n);
      logic [31:0]       w;
      logic [ADDR_W-1:0] a;
      stream_q.delete();
      exp_q.delete();
      stream_q.push_back(n[15:8]);
      stream_q.push_back(n[7:0]);
      if (int'(n) <= DEPTH) begin
         for (int i = 0; i < int'(n); i++) begin
            w = words_q[i];
            a = ADDR_W'(i);
            for (int k = 3; k >= 0; k--) stream_q.push_back(w[8*k +: 8]);
            exp_q.push_back({a, w});
         end
      end
   endtask

   task automatic finish_check(input logic [15:0] n, input logic exp_err);
      int t;
      chk("in_ready_after_last", 64'(in_ready), 64'd0);
      if (exp_err) begin
         chk("error_set", 64'(error), 64'd1);
      end else if (n == 16'd0) begin
         chk("done_len0", 64'(done), 64'd1);
         chk("cpu_hold_len0", 64'(cpu_hold), 64'd0);
      end else begin
         chk("final_wr_en", 64'(wr_en), 64'd1);
         chk("cpu_hold_fin", 64'(cpu_hold), 64'd1);
      end
      t = 0;
      while (!exp_err && done_cnt == 0 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("done_count", 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
      chk("cpu_hold_end", 64'(cpu_hold), 64'(exp_err));
      chk("error_end", 64'(error), 64'(exp_err));
      chk("in_ready_end", 64'(in_ready), 64'd0);
      chk("write_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("write_addr_data", 64'(got_q[i]), 64'(exp_q[i]));
      if (!exp_err && n == 16'd0) chk("done_latency0", 64'(done_cyc), 64'(last_accept_cyc));
      if (!exp_err && n != 16'd0) chk("done_latency", 64'(done_cyc), 64'(last_wr_cyc + 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
      chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_error"}, 64'(error), 64'd0);
   endtask

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      logic        exp_err;
      int          exp_wr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{16'd2,      32'h24080005, 32'hAC080004, 0, 1'b0, 2};
      vecs[1] = '{16'd0,      32'h0,        32'h0,        0, 1'b0, 0};
      vecs[2] = '{16'd33,     32'h0,        32'h0,        0, 1'b1, 0};
      vecs[3] = '{16'd1,      32'hDEADBEEF, 32'h0,        0, 1'b0, 1};
      vecs[4] = '{16'd1,      32'h11223344, 32'h0,        3, 1'b0, 1};
      vecs[5] = '{16'd32,     32'h0F1E2D3C, 32'hF0E1D2C3, 0, 1'b0, 32};
      vecs[6] = '{16'h0101,   32'h0,        32'h0,        1, 1'b1, 0};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("ready_after_release", 64'(in_ready), 64'd1);

      // table-driven loads
      for (int v = 0; v < 7; v++) begin
         do_reload();
         words_q.delete();
         for (int i = 0; i < int'(vecs[v].n) && int'(vecs[v].n) <= DEPTH; i++)
            words_q.push_back((i % 2 == 0) ? vecs[v].w0 : vecs[v].w1);
         build(vecs[v].n);
         play(vecs[v].gap, vecs[v].gap);
         finish_check(vecs[v].n, vecs[v].exp_err);
         chk("table_write_count", 64'(got_q.size()), 64'(vecs[v].exp_wr));
      end

      // randomized loads against the model
      for (int r = 0; r < 10; r++) begin
         logic [15:0] n;
         do_reload();
         n = (r == 7) ? 16'($urandom_range(300, 33)) : 16'($urandom_range(6, 0));
         words_q.delete();
         for (int i = 0; i < int'(n) && int'(n) <= DEPTH; i++) words_q.push_back($urandom);
         build(n);
         play(0, 2);
         finish_check(n, int'(n) > DEPTH);
      end

      // reload after two data bytes of a 2-word load, colliding with a byte offer
      do_reload();
      words_q.delete();
      words_q.push_back(32'h12345678);
      words_q.push_back(32'h9ABCDEF0);
      build(16'd2);
      while (stream_q.size() > 4) void'(stream_q.pop_back());
      play(0, 0);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("partial_no_write", 64'(got_q.size()), 64'd0);
      chk("partial_reload_ready", 64'(in_ready), 64'd1);
      chk("partial_reload_hold", 64'(cpu_hold), 64'd1);
      got_q.delete();
      done_cnt = 0;
      words_q.delete();
      words_q.push_back(32'hCAFEBABE);
      build(16'd1);
      play(0, 0);
      finish_check(16'd1, 1'b0);

      // reset asserted in the middle of a word
      do_reload();
      words_q.delete();
      words_q.push_back(32'hAABBCCDD);
      build(16'd1);
      while (stream_q.size() > 4) void'(stream_q.pop_back());
      play(0, 0);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      #1;
      check_reset_outputs("mid_reset");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check_reset_outputs("held_reset");
      end
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("ready_at_release", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("ready_one_edge_after", 64'(in_ready), 64'd1);
      chk("no_partial_write", 64'(got_q.size()), 64'd0);
      got_q.delete();
      done_cnt = 0;
      words_q.delete();
      words_q.push_back(32'h01020304);
      build(16'd1);
      play(0, 0);
      finish_check(16'd1, 1'b0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
